hdb3_polar_mapper: RTL and testbench
====================================

// Module: hdb3_polar_mapper
// PURPOSE
//  Multi-channel polarity assigner for the HDB3/AMI encoder chain. It takes the
//  ternary symbols produced by the B/V substitution stage, tagged with a
//  channel number, and maps them to signed line pulses.
//  - Keeps separate polarity, violation and DC-disparity state for each channel.
//  - Uses valid/ready flow control on both sides, with one registered output stage.
//  - Feeds the line driver / TDM serialiser.
// PARAMETERS
//  NUM_CH    4   number of channels (>=1); CH_W = max(1,$clog2(NUM_CH)) is a localparam
//  DISP_W    4   width of the signed running-disparity counter per channel (>=2)
//  INIT_POL  0   polarity of the first mark after reset/clear: 0 = +1, 1 = -1
// PORTS
//  Clk        in   1       rising-edge clock
//  Rst_n      in   1       asynchronous active-low reset
//  Clr        in   1       synchronous clear of all channel state; In_Ready=0 while high
//  Mode       in   1       0 = AMI, 1 = HDB3; sampled with each accepted symbol
//  In_Valid   in   1       input symbol valid
//  In_Ready   out  1       input can be accepted
//  In_Sym     in   2       00 zero, 01 mark, 10 B pulse, 11 V pulse
//  In_Ch      in   CH_W    channel tag; a value >= NUM_CH is dropped (accepted, no output)
//  Out_Valid  out  1       output register holds a symbol
//  Out_Ready  in   1       downstream accepts the output
//  Out_Sym    out  2       00 zero, 01 +1, 10 -1 (11 never driven)
//  Out_Ch     out  CH_W    channel tag of Out_Sym
//  Out_Disp   out  DISP_W  signed disparity of Out_Ch after this symbol
//  Viol_Err   out  1       high with Out_Valid when the symbol is an illegal V (see below)
// BEHAVIOUR
//  - Reset (Rst_n=0, async):
//    - Out_Valid=0, Out_Sym=00, Out_Ch=0, Out_Disp=0, Viol_Err=0.
//    - Every channel: last_pol=~INIT_POL, disp=0, last_v=0.
//  - Handshake:
//    - In_Ready = !Clr && (!Out_Valid || Out_Ready).
//    - A symbol is accepted when In_Valid && In_Ready.
//    - Out_* hold stable while Out_Valid && !Out_Ready.
//  - Latency: 1 cycle. A symbol accepted at edge N appears on Out_* after edge N.
//    Full throughput: one symbol per cycle, back-to-back on the same channel.
//  - Per-channel state updates at the accepting edge, so the next symbol for that
//    channel sees the updated state.
//  - Mapping for channel c, with p = last_pol[c] (0 = +, 1 = -):
//    - zero: out 00. State unchanged except last_v[c] is kept.
//    - mark or B, and V in AMI mode: out = pulse of polarity ~p; last_pol[c] <= ~p;
//      last_v[c] <= 0.
//    - V in HDB3 mode: out = pulse of polarity p (same as the previous pulse);
//      last_pol unchanged; last_v[c] <= 1.
//  - Viol_Err (HDB3 only): set when an accepted V finds last_v[c]=1, meaning no mark
//    or B since the previous V. The pulse is still mapped normally. Viol_Err is
//    always 0 in AMI mode.
//  - Disparity:
//    - disp[c] += 1 for a +1 pulse, -= 1 for a -1 pulse.
//    - Saturates at +(2^(DISP_W-1)-1) and -(2^(DISP_W-1)-1), with no wrap.
//    - Out_Disp shows the updated value.
//  - Clr: all channel state returns to its reset values at the next edge. No symbol is
//    accepted that cycle. The output register and its handshake are unaffected.
//  - Channel tag >= NUM_CH: In_Ready follows the normal rule, the symbol is accepted,
//    Out_Valid is not set, and no state changes.
//  - Mode may change between any two symbols. Per-channel state is shared by both modes.
// TESTING
//  - Reset, INIT_POL=0, HDB3, ch0, symbols 01,01,00,01 -> Out_Sym 01,10,00,01;
//    Out_Disp 1,0,0,1.
//  - HDB3, ch0, symbols 01,00,00,00,11,10,00,00,11 -> 01,00,00,00,01,10,00,00,10;
//    Viol_Err=0 throughout.
//  - AMI, symbols 01,11,01 -> 01,10,01. HDB3, symbols 01,11,11 -> second 11 gives
//    Viol_Err=1 with Out_Sym=01.
//  - Interleave ch0=01 and ch1=01 alternately ×3 -> each channel alternates
//    01,10,01 independently.
//  - DISP_W=4: seven +1 pulses on a channel via mark/V patterns -> Out_Disp holds at 7.
//  - Hold Out_Ready=0 for 3 cycles with In_Valid=1 -> In_Ready=0 and Out_* stable.
//  - Assert Clr mid-stream -> next mark is 01.
//  - Drop Rst_n mid-symbol -> Out_Valid=0 immediately.

Source files
------------

// File: rtl/hdb3_polar_mapper.sv
// Per-channel HDB3/AMI polarity assigner: maps B/V-substituted ternary symbols to signed
// line pulses, tracking polarity, violation and saturating DC disparity per channel.
module hdb3_polar_mapper #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DISP_W   = 4,
  parameter bit          INIT_POL = 1'b0,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Clr,
  input  logic                     Mode,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [1:0]               In_Sym,
  input  logic [CH_W-1:0]          In_Ch,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [1:0]               Out_Sym,
  output logic [CH_W-1:0]          Out_Ch,
  output logic signed [DISP_W-1:0] Out_Disp,
  output logic                     Viol_Err
);

  localparam logic [CH_W:0]          NumChW  = (CH_W+1)'(NUM_CH);
  localparam logic signed [DISP_W-1:0] DispOne = DISP_W'(1);
  localparam logic signed [DISP_W-1:0] DispMax = {1'b0, {(DISP_W-1){1'b1}}};
  localparam logic signed [DISP_W-1:0] DispMin = -DispMax;

  logic [NUM_CH-1:0]        last_pol_q, last_pol_d;
  logic [NUM_CH-1:0]        last_v_q, last_v_d;
  logic signed [DISP_W-1:0] disp_q [NUM_CH];
  logic signed [DISP_W-1:0] disp_d [NUM_CH];

  logic                     out_valid_q, out_valid_d;
  logic [1:0]               out_sym_q, out_sym_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic signed [DISP_W-1:0] out_disp_q, out_disp_d;
  logic                     viol_q, viol_d;

  logic                     accept, ch_ok;
  logic [CH_W-1:0]          ch_idx;
  logic                     p, pulse, pol, viol, new_pol, new_v;
  logic signed [DISP_W-1:0] disp_cur, disp_new;

  assign In_Ready  = !Clr && (!out_valid_q || Out_Ready);
  assign accept    = In_Valid && In_Ready;
  assign ch_ok     = {1'b0, In_Ch} < NumChW;
  // Out-of-range tags are steered to channel 0 for reads only; they never write state.
  assign ch_idx    = ch_ok ? In_Ch : '0;
  assign Out_Valid = out_valid_q;
  assign Out_Sym   = out_sym_q;
  assign Out_Ch    = out_ch_q;
  assign Out_Disp  = out_disp_q;
  assign Viol_Err  = viol_q;

  always_comb begin
    p        = last_pol_q[ch_idx];
    disp_cur = disp_q[ch_idx];
    pulse    = 1'b0;
    pol      = 1'b0;
    viol     = 1'b0;
    new_pol  = p;
    new_v    = last_v_q[ch_idx];
    case (In_Sym)
      2'b01, 2'b10: begin
        pulse   = 1'b1;
        pol     = ~p;
        new_pol = ~p;
        new_v   = 1'b0;
      end
      2'b11: begin
        pulse = 1'b1;
        if (Mode) begin
          pol   = p;
          new_v = 1'b1;
          viol  = last_v_q[ch_idx];
        end else begin
          pol     = ~p;
          new_pol = ~p;
          new_v   = 1'b0;
        end
      end
      default: ;
    endcase

    disp_new = disp_cur;
    if (pulse && !pol && disp_cur != DispMax) disp_new = disp_cur + DispOne;
    if (pulse && pol && disp_cur != DispMin)  disp_new = disp_cur - DispOne;
  end

  always_comb begin
    last_pol_d  = last_pol_q;
    last_v_d    = last_v_q;
    disp_d      = disp_q;
    out_valid_d = out_valid_q && !Out_Ready;
    out_sym_d   = out_sym_q;
    out_ch_d    = out_ch_q;
    out_disp_d  = out_disp_q;
    viol_d      = viol_q;
    if (Clr) begin
      last_pol_d = {NUM_CH{~INIT_POL}};
      last_v_d   = '0;
      for (int i = 0; i < NUM_CH; i++) disp_d[i] = '0;
    end else if (accept && ch_ok) begin
      last_pol_d[ch_idx] = new_pol;
      last_v_d[ch_idx]   = new_v;
      disp_d[ch_idx]     = disp_new;
      out_valid_d        = 1'b1;
      out_sym_d          = pulse ? (pol ? 2'b10 : 2'b01) : 2'b00;
      out_ch_d           = In_Ch;
      out_disp_d         = disp_new;
      viol_d             = viol;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_pol_q  <= {NUM_CH{~INIT_POL}};
      last_v_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) disp_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_ch_q    <= '0;
      out_disp_q  <= '0;
      viol_q      <= 1'b0;
    end else begin
      last_pol_q  <= last_pol_d;
      last_v_q    <= last_v_d;
      disp_q      <= disp_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_ch_q    <= out_ch_d;
      out_disp_q  <= out_disp_d;
      viol_q      <= viol_d;
    end
  end

endmodule

// File: tb/tb_hdb3_polar_mapper.sv
// Randomised and directed bench for hdb3_polar_mapper against a per-channel pulse-sign model.
module tb_hdb3_polar_mapper;
  localparam int NUM_CH = 3;
  localparam int DISP_W = 4;
  localparam bit INIT_POL = 1'b0;
  localparam int CH_W = 2;
  localparam int DMAX = (1 << (DISP_W - 1)) - 1;

  logic Clk = 0, Rst_n = 0, Clr = 0, Mode = 0, In_Valid = 0, Out_Ready = 1;
  logic In_Ready, Out_Valid, Viol_Err;
  logic [1:0] In_Sym = 0, Out_Sym;
  logic [CH_W-1:0] In_Ch = 0, Out_Ch;
  logic signed [DISP_W-1:0] Out_Disp;

  hdb3_polar_mapper #(.NUM_CH(NUM_CH), .DISP_W(DISP_W), .INIT_POL(INIT_POL)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Mode(Mode), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .In_Sym(In_Sym), .In_Ch(In_Ch), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Sym(Out_Sym), .Out_Ch(Out_Ch), .Out_Disp(Out_Disp),
    .Viol_Err(Viol_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct { int sym; int ch; int disp; int viol; } ent_t;
  ent_t exp_q[$];
  ent_t log_q[$];
  int checks = 0, errors = 0;
  int lastp [NUM_CH];
  int lastv [NUM_CH];
  int disp [NUM_CH];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      lastp[c] = INIT_POL ? 1 : -1;
      lastv[c] = 0;
      disp[c] = 0;
    end
  endfunction

  // Pulse sign as +1/-1 integers; HDB3 V repeats the last sign, everything else alternates.
  function automatic ent_t model_step(input int c, input int s, input bit hdb3);
    ent_t e;
    int sg = 0;
    e.viol = 0;
    if (s == 1 || s == 2 || (s == 3 && !hdb3)) begin
      sg = -lastp[c]; lastp[c] = sg; lastv[c] = 0;
    end else if (s == 3) begin
      sg = lastp[c]; e.viol = lastv[c]; lastv[c] = 1;
    end
    disp[c] = disp[c] + sg;
    if (disp[c] > DMAX) disp[c] = DMAX;
    if (disp[c] < -DMAX) disp[c] = -DMAX;
    e.sym = (sg == 1) ? 1 : (sg == -1) ? 2 : 0;
    e.ch = c;
    e.disp = disp[c];
    return e;
  endfunction

  always @(negedge Clk) begin
    if (!Rst_n) begin
      model_clear();
      exp_q.delete();
    end else begin
      ent_t e;
      bit exp_ready;
      exp_ready = !Clr && (exp_q.size() == 0 || Out_Ready);
      check("in_ready", int'(In_Ready), int'(exp_ready));
      check("out_valid", int'(Out_Valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_sym", int'(Out_Sym), exp_q[0].sym);
        check("out_ch", int'(Out_Ch), exp_q[0].ch);
        check("out_disp", int'(Out_Disp), exp_q[0].disp);
        check("viol_err", int'(Viol_Err), exp_q[0].viol);
      end
      if (Out_Valid && Out_Ready) begin
        e.sym = int'(Out_Sym); e.ch = int'(Out_Ch);
        e.disp = int'(Out_Disp); e.viol = int'(Viol_Err);
        log_q.push_back(e);
      end
      if (exp_q.size() > 0 && Out_Ready) void'(exp_q.pop_front());
      if (Clr) model_clear();
      else if (In_Valid && exp_ready && int'(In_Ch) < NUM_CH)
        exp_q.push_back(model_step(int'(In_Ch), int'(In_Sym), Mode));
    end
  end

  task automatic send(input int ch, input int sym, input bit md);
    int n;
    In_Valid = 1; In_Ch = CH_W'(ch); In_Sym = 2'(sym); Mode = md;
    for (n = 0; n < 100; n++) begin
      @(negedge Clk);
      if (In_Ready) break;
    end
    if (n == 100) check("send_timeout", 0, 1);
    @(posedge Clk); #1;
    In_Valid = 0;
  endtask

  task automatic do_clr();
    Clr = 1; @(posedge Clk); #1; Clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  int base;
  int syms [$];
  int expo [$];
  logic [1:0] held_sym;
  logic signed [DISP_W-1:0] held_disp;

  initial begin
    model_clear();
    #12 Rst_n = 1;
    @(posedge Clk); #1;
    check("rst_out_valid", int'(Out_Valid), 0);
    check("rst_out_disp", int'(Out_Disp), 0);

    // HDB3 ch0: 01,01,00,01 -> 01,10,00,01 with disparity 1,0,0,1
    base = log_q.size();
    syms = '{1, 1, 0, 1};
    foreach (syms[i]) send(0, syms[i], 1);
    idle(2);
    expo = '{1, 2, 0, 1};
    foreach (expo[i]) check("t1_sym", log_q[base+i].sym, expo[i]);
    expo = '{1, 0, 0, 1};
    foreach (expo[i]) check("t1_disp", log_q[base+i].disp, expo[i]);

    do_clr();
    base = log_q.size();
    syms = '{1, 0, 0, 0, 3, 2, 0, 0, 3};
    foreach (syms[i]) send(0, syms[i], 1);
    idle(2);
    expo = '{1, 0, 0, 0, 1, 2, 0, 0, 2};
    foreach (expo[i]) begin
      check("t2_sym", log_q[base+i].sym, expo[i]);
      check("t2_viol", log_q[base+i].viol, 0);
    end

    do_clr();
    base = log_q.size();
    syms = '{1, 3, 1};
    foreach (syms[i]) send(1, syms[i], 0);
    idle(2);
    expo = '{1, 2, 1};
    foreach (expo[i]) check("t3_ami_sym", log_q[base+i].sym, expo[i]);

    do_clr();
    base = log_q.size();
    syms = '{1, 3, 3};
    foreach (syms[i]) send(1, syms[i], 1);
    idle(2);
    check("t3_v2_sym", log_q[base+2].sym, 1);
    check("t3_v2_viol", log_q[base+2].viol, 1);
    check("t3_v1_viol", log_q[base+1].viol, 0);

    do_clr();
    base = log_q.size();
    repeat (3) begin send(0, 1, 1); send(1, 1, 1); end
    idle(2);
    expo = '{1, 1, 2, 2, 1, 1};
    foreach (expo[i]) check("t4_interleave", log_q[base+i].sym, expo[i]);

    do_clr();
    base = log_q.size();
    send(2, 1, 1);
    repeat (9) send(2, 3, 1);
    idle(2);
    check("t5_disp_at7", log_q[base+6].disp, 7);
    check("t5_disp_sat", log_q[base+9].disp, 7);
    check("t5_sym_sat", log_q[base+9].sym, 1);

    // Out-of-range tag: accepted, no output, no state change on ch0
    do_clr();
    base = log_q.size();
    send(3, 1, 1);
    send(0, 1, 1);
    idle(2);
    check("t6_drop_count", log_q.size() - base, 1);
    check("t6_drop_sym", log_q[base].sym, 1);

    // Backpressure: held output must not move and input must stall
    Out_Ready = 0;
    send(0, 1, 1);
    held_sym = Out_Sym; held_disp = Out_Disp;
    In_Valid = 1; In_Ch = 0; In_Sym = 2'b01; Mode = 1;
    repeat (3) begin
      @(negedge Clk);
      check("t7_in_ready", int'(In_Ready), 0);
      check("t7_hold_sym", int'(Out_Sym), int'(held_sym));
      check("t7_hold_disp", int'(Out_Disp), int'(held_disp));
    end
    Out_Ready = 1;
    @(posedge Clk); #1;
    In_Valid = 0;
    idle(2);

    do_clr();
    send(0, 1, 1);
    send(0, 1, 1);
    do_clr();
    base = log_q.size();
    send(0, 1, 1);
    idle(2);
    check("t8_clr_mark", log_q[base].sym, 1);
    check("t8_clr_disp", log_q[base].disp, 1);

    // Randomised traffic with backpressure, clears and dropped tags
    for (int i = 0; i < 3000; i++) begin
      In_Valid  = ($urandom_range(0, 3) != 0);
      In_Sym    = 2'($urandom_range(0, 3));
      In_Ch     = CH_W'($urandom_range(0, 3));
      Mode      = 1'($urandom_range(0, 1));
      Out_Ready = ($urandom_range(0, 3) != 0);
      Clr       = ($urandom_range(0, 99) == 0);
      @(posedge Clk); #1;
    end
    In_Valid = 0; Clr = 0; Out_Ready = 1;
    idle(2);

    // Asynchronous reset mid-cycle with a symbol pending
    Out_Ready = 0;
    send(1, 1, 1);
    In_Valid = 1; In_Sym = 2'b01;
    #2 Rst_n = 0;
    #1;
    check("t9_rst_valid", int'(Out_Valid), 0);
    check("t9_rst_sym", int'(Out_Sym), 0);
    check("t9_rst_disp", int'(Out_Disp), 0);
    In_Valid = 0; Out_Ready = 1;
    idle(2);
    Rst_n = 1;
    base = log_q.size();
    send(1, 1, 1);
    idle(2);
    check("t9_post_rst_sym", log_q[base].sym, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
